// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, talks to a single-outstanding in-order instruction memory,
// and drives the F->D register (InstrD/PCD/PCPlus4D/ValidD) into decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pcf_plus4;
  logic        acc;
  logic        word_avail;
  logic [31:0] word;

  always_comb begin
    pcf_plus4  = pcf_q + 32'd4;
    acc        = imem_rvalid & ~StallD & ~FlushD & ~PCSrcE;
    state_d    = state_q;
    pcf_d      = pcf_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    imem_req   = 1'b0;
    imem_addr  = pcf_q;
    word_avail = 1'b0;
    word       = imem_rdata;

    case (state_q)
      ISSUE: begin
        // The request goes out even on redirect; its response is then wrong-path.
        imem_req = 1'b1;
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = imem_rvalid ? ISSUE : DROP;
        end else if (acc) begin
          word_avail = 1'b1;
          pcf_d      = pcf_plus4;
          imem_req   = 1'b1;
          imem_addr  = pcf_plus4;
        end else if (imem_rvalid) begin
          hold_d     = imem_rdata;
          hold_vld_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        word = hold_q;
        if (PCSrcE) begin
          hold_vld_d = 1'b0;
          pcf_d      = PCTargetE;
          state_d    = ISSUE;
        end else if (!StallD && !FlushD) begin
          word_avail = hold_vld_q;
          hold_vld_d = 1'b0;
          pcf_d      = pcf_plus4;
          state_d    = ISSUE;
        end
      end
      DROP: begin
        if (PCSrcE) pcf_d = PCTargetE;
        if (imem_rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase

    // Reset forces ISSUE asynchronously; keep the request quiet until it releases.
    if (reset) imem_req = 1'b0;
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (word_avail) begin
        instr_d = word;
        pcd_d   = pcf_q;
        pcp4_d  = pcf_plus4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ISSUE;
      pcf_q      <= RESET_PC;
      hold_q     <= 32'd0;
      hold_vld_q <= 1'b0;
      instr_q    <= NOP_INSTR;
      pcd_q      <= 32'd0;
      pcp4_q     <= 32'd4;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-programmable instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int          n_chk;
  int          n_fail;
  logic        pend;
  int          cnt;
  int          lat;
  logic [31:0] paddr;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'd8) ? 32'h0050_0093 : (32'hA000_0000 | a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask

  task automatic chk_d(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, ValidD}, {31'd0, v});
    chk({tag, "_instr"}, InstrD, ins);
    chk({tag, "_pcd"}, PCD, pc);
    chk({tag, "_pcp4"}, PCPlus4D, pc + 32'd4);
  endtask

  // One clock: the memory model captures a request seen this cycle and answers after lat cycles.
  task automatic cyc();
    logic        r;
    logic [31:0] a;
    r = imem_req;
    a = imem_addr;
    if (r) chk("one_outstanding", {31'd0, pend}, 32'd0);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (r) begin
      pend  = 1'b1;
      paddr = a;
      cnt   = lat;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(paddr);
        pend        = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int l);
    reset       = 1'b1;
    PCSrcE      = 1'b0;
    PCTargetE   = 32'd0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    imem_rvalid = 1'b0;
    pend        = 1'b0;
    lat         = l;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'd0; StallD = 1'b0; FlushD = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    pend = 1'b0; cnt = 0; lat = 1; paddr = 32'd0;
    #2;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk_d("rst", 1'b0, NOP, 32'd0);

    // 1-cycle memory, streaming
    do_reset(1);
    chk_req("s_c0", 1'b1, 32'd0);
    cyc();
    chk_req("s_c1", 1'b1, 32'd4);
    chk("s_c1_valid", {31'd0, ValidD}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_d("s_stream", 1'b1, word(32'(4 * i)), 32'(4 * i));
      chk_req("s_stream", 1'b1, 32'(4 * i + 8));
    end

    // 3-cycle memory
    do_reset(3);
    chk_req("l3_c0", 1'b1, 32'd0);
    cyc(); chk_req("l3_c1", 1'b0, 32'd0);
    cyc(); chk_req("l3_c2", 1'b0, 32'd0);
    cyc(); chk_req("l3_c3", 1'b1, 32'd4);
    cyc(); chk_d("l3_c4", 1'b1, word(32'd0), 32'd0);
    cyc(); chk_d("l3_c5", 1'b0, NOP, 32'd0);
    cyc(); chk_d("l3_c6", 1'b0, NOP, 32'd0);
    chk_req("l3_c6", 1'b1, 32'd8);
    cyc(); chk_d("l3_c7", 1'b1, word(32'd4), 32'd4);

    // StallD for 3 cycles while the word for PC 8 returns
    do_reset(1);
    cyc(); cyc(); cyc();
    StallD = 1'b1; #1;
    chk_req("st_c3", 1'b0, 32'd0);
    cyc(); chk_d("st_c4", 1'b1, word(32'd4), 32'd4);
    chk_req("st_c4", 1'b0, 32'd0);
    cyc(); chk_d("st_c5", 1'b1, word(32'd4), 32'd4);
    cyc(); chk_d("st_c6", 1'b1, word(32'd4), 32'd4);
    StallD = 1'b0; #1;
    chk_req("st_c6", 1'b0, 32'd0);
    cyc(); chk_d("st_c7", 1'b1, 32'h0050_0093, 32'd8);
    chk_req("st_c7", 1'b1, 32'd12);

    // Redirect + flush while 0x10 is outstanding
    do_reset(1);
    cyc(); cyc(); cyc(); cyc();
    lat = 2;
    chk_req("rd_c4", 1'b1, 32'h10);
    cyc(); chk_d("rd_c5", 1'b1, word(32'hC), 32'hC);
    PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1; #1;
    chk_req("rd_c5", 1'b0, 32'd0);
    cyc(); chk_d("rd_c6", 1'b0, NOP, 32'hC);
    PCSrcE = 1'b0; FlushD = 1'b0; #1;
    chk_req("rd_c6", 1'b0, 32'd0);
    cyc(); chk_req("rd_c7", 1'b1, 32'h100);
    chk_d("rd_c7", 1'b0, NOP, 32'hC);
    cyc(); chk_d("rd_c8", 1'b0, NOP, 32'hC);
    cyc(); chk_d("rd_c9", 1'b0, NOP, 32'hC);
    chk_req("rd_c9", 1'b1, 32'h104);
    cyc(); chk_d("rd_c10", 1'b1, word(32'h100), 32'h100);

    // Chained redirects while dropping a wrong-path response
    do_reset(3);
    PCSrcE = 1'b1; PCTargetE = 32'h100; #1;
    chk_req("dr_c0", 1'b1, 32'd0);
    cyc(); PCTargetE = 32'h200; #1;
    chk_req("dr_c1", 1'b0, 32'd0);
    cyc(); PCTargetE = 32'h300; #1;
    chk_req("dr_c2", 1'b0, 32'd0);
    cyc(); PCSrcE = 1'b0; #1;
    chk_req("dr_c3", 1'b0, 32'd0);
    cyc(); chk_req("dr_c4", 1'b1, 32'h300);
    chk("dr_c4_valid", {31'd0, ValidD}, 32'd0);

    // Async reset mid-WAIT, stale response, then wrap-around
    do_reset(1);
    cyc(); cyc();
    lat = 2;
    cyc(); chk_d("ar_c3", 1'b1, word(32'd4), 32'd4);
    #2; reset = 1'b1; #1;
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    chk_d("ar_rst", 1'b0, NOP, 32'd0);
    cyc();
    reset = 1'b0; #1;
    chk_req("ar_c4", 1'b1, 32'd0);
    cyc(); chk_d("ar_c5", 1'b0, NOP, 32'd0);
    cyc(); chk_req("ar_c6", 1'b1, 32'd4);
    cyc(); chk_d("ar_c7", 1'b1, word(32'd0), 32'd0);
    lat = 1;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; #1;
    chk_req("wr_c7", 1'b0, 32'd0);
    cyc(); PCSrcE = 1'b0; #1;
    chk_req("wr_c8", 1'b0, 32'd0);
    chk("wr_c8_valid", {31'd0, ValidD}, 32'd0);
    cyc(); chk_req("wr_c9", 1'b1, 32'hFFFF_FFFC);
    cyc(); chk_req("wr_c10", 1'b1, 32'd0);
    cyc();
    chk("wr_c11_valid", {31'd0, ValidD}, 32'd1);
    chk("wr_c11_instr", InstrD, word(32'hFFFF_FFFC));
    chk("wr_c11_pcd", PCD, 32'hFFFF_FFFC);
    chk("wr_c11_pcp4", PCPlus4D, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
